key_debounce10: RTL and testbench



---
 rtl/key_debounce10.sv | 86 ++++++++
 tb/tb_key_debounce10.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/key_debounce10.sv
// Ten-channel pushbutton conditioner: 2-FF synchronizer, per-channel debounce counter,
// registered press/release events. Define KEY_INVERT_EN for active-low (pull-up) key inputs.
module key_debounce10 #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] key_in,
  output logic [9:0] key_db,
  output logic [9:0] key_press,
  output logic [9:0] key_release,
  output logic       any_key
);

  localparam int unsigned NCH   = 10;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_INVERT_EN
  localparam logic [NCH-1:0] SYNC_IDLE = '1;
`else
  localparam logic [NCH-1:0] SYNC_IDLE = '0;
`endif

  logic [NCH-1:0]   sync1;
  logic [NCH-1:0]   sync2;
  logic [NCH-1:0]   s;
  logic [NCH-1:0]   accept;
  logic [CNT_W-1:0] cnt [NCH];

  // Synchronizer keeps raw pin polarity so it can reset to the idle pin level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= SYNC_IDLE;
      sync2 <= SYNC_IDLE;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  always_comb begin
    s = sync2 ^ SYNC_IDLE;
  end

  always_comb begin
    accept = '0;
    for (int unsigned n = 0; n < NCH; n++) begin
      accept[n] = (s[n] != key_db[n]) && (cnt[n] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned n = 0; n < NCH; n++) begin
        cnt[n] <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < NCH; n++) begin
        if (s[n] == key_db[n] || accept[n]) begin
          cnt[n] <= '0;
        end else begin
          cnt[n] <= cnt[n] + 1'b1;
        end
      end
    end
  end

  // Events are registered alongside key_db, so each pulse spans the cycle after the level change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_db      <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      key_db      <= key_db ^ accept;
      key_press   <= accept & s;
      key_release <= accept & ~s;
    end
  end

  always_comb begin
    any_key = |key_db;
  end

endmodule

// File: tb/tb_key_debounce10.sv
// Scoreboard bench for key_debounce10: a sliding-window reference model pushes expected
// outputs each edge; an independent monitor pops and compares. Honours KEY_INVERT_EN.
module tb_key_debounce10;

  localparam int unsigned D = 4;
`ifdef KEY_INVERT_EN
  localparam logic [9:0] IDLE = '1;
`else
  localparam logic [9:0] IDLE = '0;
`endif

  typedef struct packed {
    logic [9:0] db;
    logic [9:0] press;
    logic [9:0] rel;
    logic       any;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] key_in = IDLE;
  logic [9:0] key_db;
  logic [9:0] key_press;
  logic [9:0] key_release;
  logic       any_key;

  int checks   = 0;
  int failures = 0;

  exp_t       q[$];
  logic [9:0] hist[$];
  logic [9:0] mdb;

  always #5 clk = ~clk;

  key_debounce10 #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_db      (key_db),
    .key_press   (key_press),
    .key_release (key_release),
    .any_key     (any_key)
  );

  // Reference: a channel flips once the last D synchronized samples (input delayed
  // two edges) all disagree with its current debounced level.
  always @(posedge clk) begin
    exp_t       e;
    logic [9:0] nd;
    bit         all;
    if (rst) begin
      hist = {};
      for (int i = 0; i < D + 2; i++) hist.push_back('0);
      mdb = '0;
      e   = '0;
    end else begin
      hist.push_back(key_in ^ IDLE);
      while (hist.size() > D + 2) void'(hist.pop_front());
      nd = mdb;
      for (int c = 0; c < 10; c++) begin
        all = 1'b1;
        for (int i = 0; i < D; i++) begin
          if (hist[i][c] == mdb[c]) all = 1'b0;
        end
        if (all) nd[c] = ~mdb[c];
      end
      e.db    = nd;
      e.press = nd & ~mdb;
      e.rel   = ~nd & mdb;
      e.any   = |nd;
      mdb     = nd;
    end
    q.push_back(e);
  end

  // Monitor
  initial begin
    exp_t e;
    exp_t act;
    forever begin
      @(posedge clk);
      #1;
      act = {key_db, key_press, key_release, any_key};
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty t=%0t actual=%h required=<queued entry>", $time, act);
      end else begin
        e = q.pop_front();
        if (act !== e) begin
          failures++;
          $display("FAIL cycle_outputs t=%0t actual db=%h press=%h rel=%h any=%b required db=%h press=%h rel=%h any=%b",
                   $time, act.db, act.press, act.rel, act.any, e.db, e.press, e.rel, e.any);
        end
      end
    end
  end

  task automatic drive(input logic [9:0] pressed, input int n);
    key_in = IDLE ^ pressed;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    #1;
    checks++;
    if ({key_db, key_press, key_release, any_key} !== '0) begin
      failures++;
      $display("FAIL async_reset_clear t=%0t actual db=%h press=%h rel=%h any=%b required all zero",
               $time, key_db, key_press, key_release, any_key);
    end
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts edges until key_db[ch] reaches val; called right after a negedge stimulus change.
  task automatic check_latency(input string name, input int ch, input logic val);
    int edges;
    edges = 0;
    while (edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (key_db[ch] == val) break;
    end
    checks++;
    if (key_db[ch] != val || edges != D + 2) begin
      failures++;
      $display("FAIL %s actual_edges=%0d level=%b required_edges=%0d level=%b",
               name, edges, key_db[ch], D + 2, val);
    end
  endtask

  initial begin
    logic [9:0] cur;
    logic [9:0] m;

    // Reset with every key held; all ten report after the full latency
    key_in = IDLE ^ 10'h3FF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_latency("reset_release_latency", 0, 1'b1);
    @(negedge clk);
    drive(10'h000, 12);

    // Clean press/release on ch3
    key_in = IDLE ^ 10'b0000001000;
    check_latency("ch3_press_latency", 3, 1'b1);
    repeat (4) @(negedge clk);
    key_in = IDLE;
    check_latency("ch3_release_latency", 3, 1'b0);
    repeat (4) @(negedge clk);

    // Bounce on ch0
    drive(10'b1, 2); drive(10'b0, 2); drive(10'b1, 2); drive(10'b0, 2);
    drive(10'b1, 10);
    drive(10'b0, 10);

    // Short glitch on ch9
    drive(10'h200, 3);
    drive(10'h000, 10);

    // Simultaneous keys
    drive(10'b1100000000, 10);
    drive(10'h000, 10);

    // Mid-count reset on ch5 (count reaches 2), then full latency after release
    drive(10'h020, 4);
    pulse_reset(1);
    check_latency("ch5_after_reset_latency", 5, 1'b1);
    @(negedge clk);
    drive(10'h000, 10);

    // Randomized bursts with sparse toggles and occasional resets
    cur = '0;
    for (int it = 0; it < 300; it++) begin
      m   = 10'($urandom & $urandom & $urandom);
      cur = cur ^ m;
      if ($urandom_range(0, 39) == 0) pulse_reset($urandom_range(1, 2));
      drive(cur, $urandom_range(1, 8));
    end
    drive(10'h000, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
